// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and winner-select helpers for reg_access_arbiter.
// The fixed-priority build is selected with REG_ARB_FIXED_PRIO_EN.
package reg_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Requests beyond NUM_REQ are zero-padded, so wrapping modulo MAX_REQ
  // gives the same winner as wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            r;
    logic [IDX_W-1:0] cand;
    r = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!r.valid && req[cand]) begin
        r.valid = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

  function automatic pick_t fixed_pick(input logic [MAX_REQ-1:0] req);
    pick_t r;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (!r.valid && req[k]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side and bank-side signals of reg_access_arbiter.
// slave = the arbiter, master = requesters plus register bank.
interface reg_access_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_write_en;
  logic [DATA_W-1:0]         mem_write_data;
  logic                      mem_read_en;
  logic [DATA_W-1:0]         mem_read_data;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_read_data,
    output gnt, done, rdata, busy,
           mem_addr, mem_write_en, mem_write_data, mem_read_en
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_read_data,
    input  gnt, done, rdata, busy,
           mem_addr, mem_write_en, mem_write_data, mem_read_en
  );
endinterface

// File: rtl/reg_access_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from ptr+1, or lowest index
// wins when REG_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);
  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  assign req_ext = MAX_REQ'(req);

`ifdef REG_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;
  assign pick       = fixed_pick(req_ext);
`else
  assign pick = rr_pick(req_ext, ptr);
`endif

  assign valid = pick.valid;
  assign idx   = pick.idx;
endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the single-port register bank between NUM_REQ masters, one
// transaction at a time. REG_ARB_FIXED_PRIO_EN selects fixed priority.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input logic                clk,
  input logic                rst_n,
  reg_access_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 2;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                arb_valid;
  logic [IDX_W-1:0]    arb_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == arb_idx) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Strobes, gnt and done are computed one state ahead so that they are
  // registered and appear exactly in the cycle of the state they belong to.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          ptr_d   = arb_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          gnt_d   = onehot(arb_idx);
          busy_d  = 1'b1;
          state_d = ISSUE;
          if (sel_we) begin
            wdata_d = sel_wdata;
            wen_d   = 1'b1;
            done_d  = onehot(arb_idx);
          end else begin
            ren_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (READ_LAT == 1) begin
          state_d = RESP;
          done_d  = onehot(win_q);
        end else begin
          state_d = RWAIT;
          cnt_d   = CNT_W'(READ_LAT - 2);
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          done_d  = onehot(win_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rdata_d = bus.mem_read_data;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_en   = wen_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_read_en    = ren_q;
  // Bank data is only valid in the RESP cycle itself, so it is passed
  // through while done is high and held in rdata_q afterwards.
  assign bus.rdata          = (state_q == RESP) ? bus.mem_read_data : rdata_q;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench for reg_access_arbiter (READ_LAT=1 and
// READ_LAT=3 instances); expectations follow REG_ARB_FIXED_PRIO_EN.
module tb_reg_access_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  reg_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) b1 ();
  reg_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) b3 ();

  reg_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  reg_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  // Bank models: data valid READ_LAT cycles after the strobe cycle.
  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];
  logic [7:0] p1, q1, q2, q3;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'(i) ^ 8'h5A;
      mem3[i] = 8'(i) ^ 8'h5A;
    end
    mem3[8'h22] = 8'h5C;
  end

  always @(posedge clk) begin
    if (b1.mem_write_en) mem1[b1.mem_addr] <= b1.mem_write_data;
    p1 <= b1.mem_read_en ? mem1[b1.mem_addr] : 8'hEE;
    if (b3.mem_write_en) mem3[b3.mem_addr] <= b3.mem_write_data;
    q1 <= b3.mem_read_en ? mem3[b3.mem_addr] : 8'hEE;
    q2 <= q1;
    q3 <= q2;
  end
  assign b1.mem_read_data = p1;
  assign b3.mem_read_data = q3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    b1.req = '0; b1.req_we = '0; b1.req_addr = '0; b1.req_wdata = '0;
    b3.req = '0; b3.req_we = '0; b3.req_addr = '0; b3.req_wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // vector layout: {gnt[1:0], done[1:0], mem_write_en, mem_read_en, busy}
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b0);
    end
    n_vec++;
    if ({b1.rdata, b1.mem_addr, b1.mem_write_data} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected %h",
               {b1.rdata, b1.mem_addr, b1.mem_write_data}, 24'h0);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    b1.req = 2'b01; b1.req_we = 2'b01; b1.req_addr = 16'h0010; b1.req_wdata = 16'h00A5;
    tick();
    n_vec++;
    if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b01_01_1_0_1) begin
      n_err++;
      $display("FAIL wr_issue: got %b expected %b",
               {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b01_01_1_0_1);
    end
    n_vec++;
    if ({b1.mem_addr, b1.mem_write_data} !== 16'h10A5) begin
      n_err++;
      $display("FAIL wr_bus: got %h expected %h", {b1.mem_addr, b1.mem_write_data}, 16'h10A5);
    end
    b1.req = 2'b00;
    tick();
    n_vec++;
    if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b0) begin
      n_err++;
      $display("FAIL wr_idle: got %b expected %b",
               {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b0);
    end
    b1.req = 2'b01; b1.req_we = 2'b00;
    tick();
    n_vec++;
    if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b01_00_0_1_1) begin
      n_err++;
      $display("FAIL rd_issue: got %b expected %b",
               {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b01_00_0_1_1);
    end
    b1.req = 2'b00;
    tick();
    n_vec++;
    if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b00_01_0_0_1) begin
      n_err++;
      $display("FAIL rd_done: got %b expected %b",
               {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b00_01_0_0_1);
    end
    n_vec++;
    if (b1.rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL rd_data: got %h expected %h", b1.rdata, 8'hA5);
    end
    tick();
    n_vec++;
    if ({b1.done, b1.busy, b1.rdata} !== {2'b00, 1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL rd_hold: got %h expected %h", {b1.done, b1.busy, b1.rdata},
               {2'b00, 1'b0, 8'hA5});
    end
  endtask

  task automatic test_round_robin();
    int unsigned e;
    int unsigned k;
    logic [1:0] g;
    do_reset();
    b1.req_we = 2'b00; b1.req_addr = 16'h3130; b1.req = 2'b11;
    for (int t = 0; t < 5; t++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      e = (t == 4) ? 1 : 0;
`else
      e = (t == 4) ? 1 : int'(t % 2);
`endif
      k = 0;
      while (b1.gnt == 2'b00 && k < 8) begin tick(); k++; end
      g = b1.gnt;
      n_vec++;
      if (g !== 2'(1 << e)) begin
        n_err++;
        $display("FAIL rr_gnt%0d: got %b expected %b", t, g, 2'(1 << e));
      end
      k = 0;
      while (b1.done == 2'b00 && k < 8) begin tick(); k++; end
      n_vec++;
      if (b1.done !== 2'(1 << e)) begin
        n_err++;
        $display("FAIL rr_done%0d: got %b expected %b", t, b1.done, 2'(1 << e));
      end
      n_vec++;
      if (b1.rdata !== (8'(8'h30 + e) ^ 8'h5A)) begin
        n_err++;
        $display("FAIL rr_rdata%0d: got %h expected %h", t, b1.rdata, 8'(8'h30 + e) ^ 8'h5A);
      end
      if (t == 3) b1.req[0] = 1'b0;
      if (t == 4) b1.req = 2'b00;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    b1.req = 2'b10; b1.req_we = 2'b10;
    b1.req_addr = 16'h00FF; b1.req_wdata = 16'h0033;
    for (int n = 0; n < 3; n++) begin
      b1.req_addr[15:8]  = 8'(8'h40 + n);
      b1.req_wdata[15:8] = 8'(8'hC0 + n);
      tick();
      n_vec++;
      if ({b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy} !== 7'b10_10_1_0_1) begin
        n_err++;
        $display("FAIL b2b_gnt%0d: got %b expected %b", n,
                 {b1.gnt, b1.done, b1.mem_write_en, b1.mem_read_en, b1.busy}, 7'b10_10_1_0_1);
      end
      n_vec++;
      if ({b1.mem_addr, b1.mem_write_data} !== {8'(8'h40 + n), 8'(8'hC0 + n)}) begin
        n_err++;
        $display("FAIL b2b_bus%0d: got %h expected %h", n, {b1.mem_addr, b1.mem_write_data},
                 {8'(8'h40 + n), 8'(8'hC0 + n)});
      end
      if (n == 2) b1.req = 2'b00;
      tick();
      n_vec++;
      if ({b1.gnt, b1.done, b1.mem_write_en, b1.busy} !== 6'b0) begin
        n_err++;
        $display("FAIL b2b_gap%0d: got %b expected %b", n,
                 {b1.gnt, b1.done, b1.mem_write_en, b1.busy}, 6'b0);
      end
    end
    tick();
    n_vec++;
    if ({mem1[8'h42], b1.rdata} !== 16'hC200) begin
      n_err++;
      $display("FAIL b2b_mem: got %h expected %h", {mem1[8'h42], b1.rdata}, 16'hC200);
    end
  endtask

  task automatic test_read_latency();
    logic [6:0] exp_v [0:4];
    exp_v[0] = 7'b01_00_0_1_1;
    exp_v[1] = 7'b00_00_0_0_1;
    exp_v[2] = 7'b00_00_0_0_1;
    exp_v[3] = 7'b00_01_0_0_1;
    exp_v[4] = 7'b00_00_0_0_0;
    do_reset();
    b3.req = 2'b01; b3.req_we = 2'b00; b3.req_addr = 16'h0022;
    for (int c = 0; c < 5; c++) begin
      tick();
      b3.req = 2'b00;
      n_vec++;
      if ({b3.gnt, b3.done, b3.mem_write_en, b3.mem_read_en, b3.busy} !== exp_v[c]) begin
        n_err++;
        $display("FAIL lat3_cyc%0d: got %b expected %b", c + 1,
                 {b3.gnt, b3.done, b3.mem_write_en, b3.mem_read_en, b3.busy}, exp_v[c]);
      end
      if (c == 3) begin
        n_vec++;
        if (b3.rdata !== 8'h5C) begin
          n_err++;
          $display("FAIL lat3_rdata: got %h expected %h", b3.rdata, 8'h5C);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    b3.req = 2'b01; b3.req_we = 2'b00; b3.req_addr = 16'h0022;
    tick();
    b3.req = 2'b00;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({b3.gnt, b3.done, b3.mem_write_en, b3.mem_read_en, b3.busy} !== 7'b0) begin
      n_err++;
      $display("FAIL rstmid_ctrl: got %b expected %b",
               {b3.gnt, b3.done, b3.mem_write_en, b3.mem_read_en, b3.busy}, 7'b0);
    end
    n_vec++;
    if ({b3.rdata, b3.mem_addr, b3.mem_write_data} !== 24'h0) begin
      n_err++;
      $display("FAIL rstmid_data: got %h expected %h",
               {b3.rdata, b3.mem_addr, b3.mem_write_data}, 24'h0);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if ({b3.done, b3.busy} !== 3'b0) begin
        n_err++;
        $display("FAIL rstmid_nodone%0d: got %b expected %b", c, {b3.done, b3.busy}, 3'b0);
      end
    end
    b3.req = 2'b11; b3.req_addr = 16'h2122;
    tick();
    b3.req = 2'b00;
    n_vec++;
    if (b3.gnt !== 2'b01) begin
      n_err++;
      $display("FAIL rstmid_first_gnt: got %b expected %b", b3.gnt, 2'b01);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_read_latency();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
